// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : MEM-stage data-memory responder, byte-lane RAM + wait states
// Revision: 1.0
// ============================================================================
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          c_AW          = $clog2(DEPTH_WORDS);
   localparam logic [32:0] c_RANGE_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam bit          c_LIVE        = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;
   logic [3:0]  r_wait_cnt;

   logic        r_we;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic            w_accept;
   logic            w_commit;
   logic            w_we;
   logic [1:0]      w_size;
   logic [31:0]     w_addr;
   logic [3:0]      w_wstrb;
   logic [31:0]     w_wdata;
   logic [31:0]     w_off;
   logic            w_range_err;
   logic            w_align_err;
   logic            w_err;
   logic [c_AW-1:0] w_idx;

   assign w_accept = req_valid && r_req_ready;

   // With no wait states the commit edge is the accept edge, so the live request is used.
   assign w_we    = c_LIVE ? req_we    : r_we;
   assign w_size  = c_LIVE ? req_size  : r_size;
   assign w_addr  = c_LIVE ? req_addr  : r_addr;
   assign w_wstrb = c_LIVE ? req_wstrb : r_wstrb;
   assign w_wdata = c_LIVE ? req_wdata : r_wdata;

   assign w_commit = c_LIVE ? w_accept : ((r_state == S_WAIT) && (r_wait_cnt == 4'd0));

   assign w_off       = w_addr - BASE_ADDR;
   assign w_range_err = (w_addr < BASE_ADDR) || ({1'b0, w_off} >= c_RANGE_BYTES);
   // BASE_ADDR is word aligned, so offset low bits equal address low bits.
   assign w_align_err = ((w_size == 2'd1) && w_off[0])
                     || ((w_size == 2'd2) && (w_off[1:0] != 2'b00))
                     ||  (w_size == 2'd3);
   assign w_err       = w_range_err || w_align_err;
   assign w_idx       = w_off[c_AW+1:2];

   always_ff @(posedge aclk) begin
      if (w_commit && !w_err && w_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_wstrb[i]) begin
               mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
         r_wait_cnt   <= 4'd0;
         r_we         <= 1'b0;
         r_size       <= 2'd0;
         r_addr       <= 32'd0;
         r_wstrb      <= 4'd0;
         r_wdata      <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req_ready <= 1'b1;
               if (w_accept) begin
                  r_we        <= req_we;
                  r_size      <= req_size;
                  r_addr      <= req_addr;
                  r_wstrb     <= req_wstrb;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (WAIT_CYCLES > 0) begin
                     r_state    <= S_WAIT;
                     r_wait_cnt <= 4'(WAIT_CYCLES - 1);
                  end else begin
                     r_state    <= S_RESP;
                  end
               end
            end
            S_WAIT: begin
               if (r_wait_cnt == 4'd0) begin
                  r_state <= S_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_state      <= S_IDLE;
                  r_resp_valid <= 1'b0;
                  r_resp_rdata <= 32'd0;
                  r_resp_err   <= 1'b0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b0;
            end
         endcase

         if (w_commit) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= (w_err || w_we) ? 32'd0 : mem[w_idx];
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed bench for dmem_responder (WAIT=1 and WAIT=0)
// Revision: 1.0
// ============================================================================
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic aresetn;

   logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
   logic [1:0]  a_req_size;
   logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
   logic [3:0]  a_req_wstrb;

   logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
   logic [1:0]  b_req_size;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
   logic [3:0]  b_req_wstrb;

   int n_tests = 0;
   int n_fail  = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut_w1 (
      .aclk(clk), .aresetn(aresetn),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_size(a_req_size), .req_addr(a_req_addr), .req_wstrb(a_req_wstrb),
      .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
      .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
      .aclk(clk), .aresetn(aresetn),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_size(b_req_size), .req_addr(b_req_addr), .req_wstrb(b_req_wstrb),
      .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction with resp_ready held high; sel=0 -> WAIT=1 DUT, sel=1 -> WAIT=0 DUT.
   task automatic do_txn(input bit sel, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
      int guard;
      @(negedge clk);
      if (!sel) begin
         a_req_we = we; a_req_size = size; a_req_addr = addr;
         a_req_wstrb = wstrb; a_req_wdata = wdata; a_resp_ready = 1'b1; a_req_valid = 1'b1;
      end else begin
         b_req_we = we; b_req_size = size; b_req_addr = addr;
         b_req_wstrb = wstrb; b_req_wdata = wdata; b_resp_ready = 1'b1; b_req_valid = 1'b1;
      end
      guard = 0;
      while (!(sel ? b_req_ready : a_req_ready) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!sel) a_req_valid = 1'b0; else b_req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(sel ? b_resp_valid : a_resp_valid) && lat < 50);
      if (lat >= 50) check("resp_timeout", 32'd0, 32'd1);
      rdata = sel ? b_resp_rdata : a_resp_rdata;
      err   = sel ? b_resp_err   : a_resp_err;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          guard;

      aresetn = 1'b0;
      a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_addr = 0;
      a_req_wstrb = 0; a_req_wdata = 0; a_resp_ready = 1;
      b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_addr = 0;
      b_req_wstrb = 0; b_req_wdata = 0; b_resp_ready = 1;

      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'd0, a_req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
      check("rst_resp_rdata", a_resp_rdata, 32'd0);
      check("rst_resp_err", {31'd0, a_resp_err}, 32'd0);
      aresetn = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", {31'd0, a_req_ready}, 32'd1);

      // Word store then load, WAIT_CYCLES=1
      do_txn(0, 1'b1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
      check("st_latency", 32'(lat), 32'd2);
      check("st_err", {31'd0, er}, 32'd0);
      check("st_rdata", rd, 32'd0);
      do_txn(0, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, rd, er, lat);
      check("ld_rdata", rd, 32'hDEADBEEF);
      check("ld_latency", 32'(lat), 32'd2);

      // Byte-lane merge into lane 2
      do_txn(0, 1'b1, 2'd0, 32'h12, 4'b0100, 32'h11223344, rd, er, lat);
      check("merge_err", {31'd0, er}, 32'd0);
      do_txn(0, 1'b0, 2'd2, 32'h10, 4'hF, 32'hFFFFFFFF, rd, er, lat);
      check("merge_rdata", rd, 32'hDE22BEEF);

      // Error cases
      do_txn(0, 1'b0, 2'd2, 32'h12, 4'h0, 32'h0, rd, er, lat);
      check("err_word_mis_err", {31'd0, er}, 32'd1);
      check("err_word_mis_rd", rd, 32'd0);
      do_txn(0, 1'b0, 2'd1, 32'h13, 4'h0, 32'h0, rd, er, lat);
      check("err_half_mis_err", {31'd0, er}, 32'd1);
      check("err_half_mis_rd", rd, 32'd0);
      do_txn(0, 1'b0, 2'd2, 32'h1000, 4'h0, 32'h0, rd, er, lat);
      check("err_range_err", {31'd0, er}, 32'd1);
      check("err_range_rd", rd, 32'd0);
      do_txn(0, 1'b0, 2'd2, 32'h0FFC, 4'h0, 32'h0, rd, er, lat);
      check("last_word_err", {31'd0, er}, 32'd0);
      do_txn(0, 1'b1, 2'd3, 32'h10, 4'hF, 32'h0, rd, er, lat);
      check("err_size3_err", {31'd0, er}, 32'd1);
      do_txn(0, 1'b1, 2'd2, 32'h10, 4'h0, 32'h55555555, rd, er, lat);
      check("nostrb_err", {31'd0, er}, 32'd0);
      do_txn(0, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, rd, er, lat);
      check("ram_unchanged", rd, 32'hDE22BEEF);
      do_txn(0, 1'b0, 2'd1, 32'h12, 4'h0, 32'h0, rd, er, lat);
      check("half_ok_rdata", rd, 32'hDE22BEEF);
      check("half_ok_err", {31'd0, er}, 32'd0);

      // Backpressure: hold resp_ready low for 5 cycles
      @(negedge clk);
      a_resp_ready = 1'b0;
      a_req_we = 1'b0; a_req_size = 2'd2; a_req_addr = 32'h10; a_req_valid = 1'b1;
      guard = 0;
      while (!a_req_ready && guard < 50) begin @(negedge clk); guard++; end
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      a_req_addr = 32'h1000;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!a_resp_valid && guard < 50);
      check("bp_first_rdata", a_resp_rdata, 32'hDE22BEEF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid_hold", {31'd0, a_resp_valid}, 32'd1);
         check("bp_rdata_hold", a_resp_rdata, 32'hDE22BEEF);
         check("bp_req_ready_low", {31'd0, a_req_ready}, 32'd0);
      end
      a_resp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_req_ready", {31'd0, a_req_ready}, 32'd1);
      check("bp_release_valid", {31'd0, a_resp_valid}, 32'd0);

      // WAIT_CYCLES=0 DUT: preload, then back-to-back loads with resp_ready tied high
      do_txn(1, 1'b1, 2'd2, 32'h40, 4'hF, 32'hA5A50F0F, rd, er, lat);
      check("w0_st_latency", 32'(lat), 32'd1);
      do_txn(1, 1'b1, 2'd2, 32'h44, 4'hF, 32'h01020304, rd, er, lat);
      @(negedge clk);
      b_req_we = 1'b0; b_req_size = 2'd2; b_req_addr = 32'h40; b_req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         check("w0_b2b_valid", {31'd0, b_resp_valid}, 32'(k % 2));
         check("w0_b2b_ready", {31'd0, b_req_ready}, 32'((k + 1) % 2));
         if (k == 1) begin
            check("w0_b2b_rd0", b_resp_rdata, 32'hA5A50F0F);
            b_req_addr = 32'h44;
         end
         if (k == 3) check("w0_b2b_rd1", b_resp_rdata, 32'h01020304);
      end
      b_req_valid = 1'b0;

      // Reset during WAIT of a store
      do_txn(0, 1'b1, 2'd2, 32'h20, 4'hF, 32'h13572468, rd, er, lat);
      @(negedge clk);
      a_req_we = 1'b1; a_req_size = 2'd2; a_req_addr = 32'h20;
      a_req_wstrb = 4'hF; a_req_wdata = 32'hCAFEF00D; a_req_valid = 1'b1;
      guard = 0;
      while (!a_req_ready && guard < 50) begin @(negedge clk); guard++; end
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      aresetn = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, a_resp_valid}, 32'd0);
      check("mid_rst_req_ready", {31'd0, a_req_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_valid_hold", {31'd0, a_resp_valid}, 32'd0);
      aresetn = 1'b1;
      do_txn(0, 1'b0, 2'd2, 32'h20, 4'h0, 32'h0, rd, er, lat);
      check("mid_rst_ram_kept", rd, 32'h13572468);
      check("mid_rst_ld_err", {31'd0, er}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
